// File: rtl/game_2048_pkg.sv
// Shared constants for the 2048 input front-end and core: move direction codes,
// FSM state encoding and the fixed-priority direction encoder.
package game_2048_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic ST_READY = 1'b0;
    localparam logic ST_COOL  = 1'b1;

    typedef enum logic {
        S_READY = ST_READY,
        S_COOL  = ST_COOL
    } state_e;

    // Event vector is {right, down, left, up}; up wins, right loses.
    function automatic logic [1:0] prio_dir(input logic [3:0] ev);
        logic [1:0] dir;
        if (ev[0]) begin
            dir = DIR_UP;
        end else if (ev[1]) begin
            dir = DIR_LEFT;
        end else if (ev[2]) begin
            dir = DIR_DOWN;
        end else begin
            dir = DIR_RIGHT;
        end
        return dir;
    endfunction

endpackage

// File: rtl/game_2048_input_debounce.sv
// One push-button channel: 2-FF synchroniser, consecutive-cycle debounce
// counter, debounced level and a one-cycle rising-edge press strobe.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             level_q;
    logic             level_d;
    logic             level_prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Debounce next state: any agreement with the synchronised input restarts the count.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q[1];
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Synchroniser, debounce and edge-history registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q       <= 2'b00;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync_q       <= {sync_q[0], btn};
            level_q      <= level_d;
            level_prev_q <= level_q;
            cnt_q        <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = level_q & ~level_prev_q;

endmodule

// File: rtl/game_2048_input.sv
// Push-button front-end for the 2048 core: four debounced channels, a
// fixed-priority encoder and a cooldown FSM emitting one-cycle move pulses.
module game_2048_input
    import game_2048_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int COOLDOWN_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_left,
    input  logic       btn_down,
    input  logic       btn_right,
    output logic       move_valid,
    output logic [1:0] move_dir,
    output logic [3:0] btn_level
);

    localparam int CW = $clog2(COOLDOWN_CYCLES + 1);
    localparam logic [CW-1:0] COOL_LOAD = CW'(COOLDOWN_CYCLES - 1);

    logic [3:0]    btn_raw_s;
    logic [3:0]    level_s;
    logic [3:0]    press_s;
    logic          any_press_s;
    logic [1:0]    win_dir_s;

    state_e        state_q;
    logic          move_valid_q;
    logic [1:0]    move_dir_q;
    logic [CW-1:0] cool_cnt_q;

    assign btn_raw_s = {btn_right, btn_down, btn_left, btn_up};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk  (clk),
            .reset(reset),
            .btn  (btn_raw_s[i]),
            .level(level_s[i]),
            .press(press_s[i])
        );
    end

    assign any_press_s = |press_s;
    assign win_dir_s   = prio_dir(press_s);

    // Move FSM: accept one press in READY, then ignore everything for the cooldown window.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_READY;
            move_valid_q <= 1'b0;
            move_dir_q   <= DIR_UP;
            cool_cnt_q   <= '0;
        end else begin
            case (state_q)
                S_READY: begin
                    if (any_press_s) begin
                        move_valid_q <= 1'b1;
                        move_dir_q   <= win_dir_s;
                        cool_cnt_q   <= COOL_LOAD;
                        state_q      <= S_COOL;
                    end else begin
                        move_valid_q <= 1'b0;
                    end
                end
                S_COOL: begin
                    move_valid_q <= 1'b0;
                    if (cool_cnt_q == '0) begin
                        state_q <= S_READY;
                    end else begin
                        cool_cnt_q <= cool_cnt_q - CW'(1);
                    end
                end
                default: begin
                    move_valid_q <= 1'b0;
                    cool_cnt_q   <= '0;
                    state_q      <= S_READY;
                end
            endcase
        end
    end

    assign move_valid = move_valid_q;
    assign move_dir   = move_dir_q;
    assign btn_level  = level_s;

endmodule

// File: tb/tb_game_2048_input.sv
// Scoreboard bench for game_2048_input with DEBOUNCE_CYCLES=4, COOLDOWN_CYCLES=4:
// stimulus pushes expected pulses (cycle, dir); a forked monitor pops and compares.
module tb_game_2048_input;
    import game_2048_pkg::*;

    typedef struct {
        int         cyc;
        logic [1:0] dir;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_up, btn_left, btn_down, btn_right;
    logic       move_valid;
    logic [1:0] move_dir;
    logic [3:0] btn_level;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   exp_total = 0;
    int   accepted = 0;
    int   last_pulse = -1;
    int   core_busy = 0;
    exp_t exp_q[$];

    game_2048_input #(
        .DEBOUNCE_CYCLES(4),
        .COOLDOWN_CYCLES(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_up    (btn_up),
        .btn_left  (btn_left),
        .btn_down  (btn_down),
        .btn_right (btn_right),
        .move_valid(move_valid),
        .move_dir  (move_dir),
        .btn_level (btn_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_exp(input int at, input logic [1:0] d);
        exp_t e;
        e.cyc = at;
        e.dir = d;
        exp_q.push_back(e);
        exp_total++;
    endtask

    // Monitor: models a core that stays busy for 3 cycles after each accepted move.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                checks++;
                failures++;
                $display("FAIL missed_pulse actual=none required=cycle %0d dir %0d", e.cyc, e.dir);
            end
            if (move_valid) begin
                chk("core_overlap", core_busy, 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pulse actual=cycle %0d dir %0d required=no pulse", cyc, move_dir);
                end else begin
                    e = exp_q.pop_front();
                    checks++;
                    if (cyc != e.cyc || move_dir != e.dir) begin
                        failures++;
                        $display("FAIL pulse actual=cycle %0d dir %0d required=cycle %0d dir %0d",
                                 cyc, move_dir, e.cyc, e.dir);
                    end
                end
                if (last_pulse >= 0) begin
                    checks++;
                    if (cyc - last_pulse < 5) begin
                        failures++;
                        $display("FAIL pulse_spacing actual=%0d required>=5", cyc - last_pulse);
                    end
                end
                last_pulse = cyc;
                core_busy  = 3;
                accepted++;
            end else if (core_busy > 0) begin
                core_busy--;
            end
        end
    endtask

    initial begin
        int         c;
        int         r;
        logic [4:0] pat;
        logic [1:0] d;

        reset = 1'b1;
        {btn_up, btn_left, btn_down, btn_right} = 4'b0000;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        chk("reset_move_valid", int'(move_valid), 0);
        chk("reset_move_dir", int'(move_dir), 0);
        chk("reset_btn_level", int'(btn_level), 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Clean press of left.
        c = cyc;
        btn_left = 1'b1;
        push_exp(c + 7, DIR_LEFT);
        repeat (5) @(negedge clk);
        chk("left_level_before", int'(btn_level), 0);
        @(negedge clk);
        chk("left_level_rise", int'(btn_level), 2);
        repeat (14) @(negedge clk);
        btn_left = 1'b0;
        repeat (12) @(negedge clk);

        // Bounce on down, then a steady hold.
        pat = 5'b01101;
        c = cyc;
        push_exp(c + 12, DIR_DOWN);
        for (int i = 0; i < 5; i++) begin
            btn_down = pat[i];
            @(negedge clk);
        end
        btn_down = 1'b1;
        repeat (15) @(negedge clk);
        btn_down = 1'b0;
        repeat (12) @(negedge clk);

        // Three-cycle glitch alone.
        btn_down = 1'b1;
        repeat (3) @(negedge clk);
        btn_down = 1'b0;
        repeat (3) @(negedge clk);
        chk("glitch_level", int'(btn_level), 0);
        repeat (9) @(negedge clk);

        // Simultaneous right and up.
        c = cyc;
        btn_right = 1'b1;
        btn_up    = 1'b1;
        push_exp(c + 7, DIR_UP);
        repeat (6) @(negedge clk);
        chk("simul_level", int'(btn_level), 9);
        repeat (14) @(negedge clk);
        btn_right = 1'b0;
        btn_up    = 1'b0;
        repeat (12) @(negedge clk);

        // Cooldown drops a left press landing two cycles after the up pulse.
        c = cyc;
        btn_up = 1'b1;
        push_exp(c + 7, DIR_UP);
        repeat (2) @(negedge clk);
        btn_left = 1'b1;
        repeat (12) @(negedge clk);
        btn_up   = 1'b0;
        btn_left = 1'b0;
        repeat (12) @(negedge clk);
        c = cyc;
        btn_left = 1'b1;
        push_exp(c + 7, DIR_LEFT);
        repeat (10) @(negedge clk);
        btn_left = 1'b0;
        repeat (12) @(negedge clk);

        // Reset the cycle before a pulse is due, with up held through release.
        c = cyc;
        btn_up = 1'b1;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_move_valid", int'(move_valid), 0);
        chk("rst_mid_move_dir", int'(move_dir), 0);
        chk("rst_mid_btn_level", int'(btn_level), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        r = cyc;
        push_exp(r + 7, DIR_UP);
        repeat (12) @(negedge clk);
        btn_up = 1'b0;
        repeat (12) @(negedge clk);

        // Ten alternating up/down moves into the modelled core.
        for (int i = 0; i < 10; i++) begin
            c = cyc;
            d = (i % 2 == 0) ? DIR_UP : DIR_DOWN;
            if (i % 2 == 0) btn_up = 1'b1;
            else            btn_down = 1'b1;
            push_exp(c + 7, d);
            repeat (8) @(negedge clk);
            btn_up   = 1'b0;
            btn_down = 1'b0;
            repeat (10) @(negedge clk);
        end

        repeat (10) @(negedge clk);
        chk("exp_queue_empty", exp_q.size(), 0);
        chk("pulse_count", accepted, exp_total);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
